// File: rtl/pio_scratch_bank.sv
// Bank of NREGS PIO scratch registers (X, Y, ...) with one write, one decrement and
// one swap per enabled cycle, plus a sticky decrement-underflow flag per register.
module pio_scratch_bank #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREGS = 2,
    parameter int unsigned IDX_W = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   penable,
    input  logic                   stalled,
    input  logic                   wr_en,
    input  logic [IDX_W-1:0]       wr_idx,
    input  logic [1:0]             wr_op,
    input  logic [WIDTH-1:0]       din,
    input  logic                   dec_en,
    input  logic [IDX_W-1:0]       dec_idx,
    input  logic                   swap_en,
    input  logic [IDX_W-1:0]       swap_a,
    input  logic [IDX_W-1:0]       swap_b,
    input  logic [IDX_W-1:0]       rd_idx,
    output logic [WIDTH-1:0]       dout,
    output logic [NREGS*WIDTH-1:0] dout_all,
    output logic [NREGS-1:0]       nonzero,
    output logic                   dec_cond,
    output logic [NREGS-1:0]       underflow
);

    localparam logic [1:0] OP_INV = 2'b01;
    localparam logic [1:0] OP_REV = 2'b10;

    logic [WIDTH-1:0] regs     [NREGS];
    logic [WIDTH-1:0] regs_nxt [NREGS];
    logic [NREGS-1:0] uf_q;
    logic [NREGS-1:0] uf_nxt;
    logic [WIDTH-1:0] wr_val;
    logic             upd;
    logic             wr_ok;
    logic             dec_ok;
    logic             swap_ok;
    logic [WIDTH-1:0] swap_a_val;
    logic [WIDTH-1:0] swap_b_val;
    logic             swap_a_uf;
    logic             swap_b_uf;

    function automatic logic in_range(input logic [IDX_W-1:0] idx);
        return 32'(idx) < NREGS;
    endfunction

    // Register select by loop so an out-of-range index simply reads 0.
    function automatic logic [WIDTH-1:0] pick_reg(input logic [WIDTH-1:0] r [NREGS],
                                                  input logic [IDX_W-1:0] idx);
        logic [WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < int'(NREGS); i++) begin
            if (idx == IDX_W'(i)) v = r[i];
        end
        return v;
    endfunction

    function automatic logic pick_uf(input logic [NREGS-1:0] u, input logic [IDX_W-1:0] idx);
        logic v;
        v = 1'b0;
        for (int i = 0; i < int'(NREGS); i++) begin
            if (idx == IDX_W'(i)) v = u[i];
        end
        return v;
    endfunction

    assign upd     = penable && !stalled;
    assign wr_ok   = wr_en && in_range(wr_idx);
    assign dec_ok  = dec_en && in_range(dec_idx);
    assign swap_ok = swap_en && in_range(swap_a) && in_range(swap_b) && (swap_a != swap_b);

    // MOV-style source operation applied to the write data.
    always_comb begin
        wr_val = din;
        case (wr_op)
            OP_INV:  wr_val = ~din;
            OP_REV: begin
                for (int k = 0; k < int'(WIDTH); k++) begin
                    wr_val[k] = din[int'(WIDTH) - 1 - k];
                end
            end
            default: wr_val = din;
        endcase
    end

    always_comb begin
        swap_a_val = pick_reg(regs, swap_a);
        swap_b_val = pick_reg(regs, swap_b);
        swap_a_uf  = pick_uf(uf_q, swap_a);
        swap_b_uf  = pick_uf(uf_q, swap_b);
    end

    // Per-register next state; write overrides swap, swap suppresses decrement.
    always_comb begin
        uf_nxt = uf_q;
        for (int i = 0; i < int'(NREGS); i++) begin
            regs_nxt[i] = regs[i];
            if (swap_ok && swap_a == IDX_W'(i)) begin
                regs_nxt[i] = swap_b_val;
                uf_nxt[i]   = swap_b_uf;
            end else if (swap_ok && swap_b == IDX_W'(i)) begin
                regs_nxt[i] = swap_a_val;
                uf_nxt[i]   = swap_a_uf;
            end else if (dec_ok && dec_idx == IDX_W'(i)) begin
                regs_nxt[i] = regs[i] - WIDTH'(1);
                if (regs[i] == '0) uf_nxt[i] = 1'b1;
            end
            if (wr_ok && wr_idx == IDX_W'(i)) begin
                regs_nxt[i] = wr_val;
                uf_nxt[i]   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
            uf_q <= '0;
        end else if (upd) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= regs_nxt[i];
            end
            uf_q <= uf_nxt;
        end
    end

    // Read-side views of the current state.
    always_comb begin
        for (int i = 0; i < int'(NREGS); i++) begin
            dout_all[i*WIDTH +: WIDTH] = regs[i];
            nonzero[i]                 = |regs[i];
        end
    end

    assign dout      = pick_reg(regs, rd_idx);
    assign dec_cond  = in_range(dec_idx) && (pick_reg(regs, dec_idx) != '0);
    assign underflow = uf_q;

endmodule

// File: tb/tb_pio_scratch_bank.sv
// Randomised + directed bench for pio_scratch_bank (three registers, 2-bit indices so
// index 3 exercises the out-of-range paths) against an array-based reference model.
module tb_pio_scratch_bank;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned NREGS = 3;
    localparam int unsigned IDX_W = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              penable;
    logic              stalled;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [1:0]        wr_op;
    logic [WIDTH-1:0]  din;
    logic              dec_en;
    logic [IDX_W-1:0]  dec_idx;
    logic              swap_en;
    logic [IDX_W-1:0]  swap_a;
    logic [IDX_W-1:0]  swap_b;
    logic [IDX_W-1:0]  rd_idx;
    logic [WIDTH-1:0]  dout;
    logic [NREGS*WIDTH-1:0] dout_all;
    logic [NREGS-1:0]  nonzero;
    logic              dec_cond;
    logic [NREGS-1:0]  underflow;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_regs [3];
    logic [2:0]  m_uf;

    pio_scratch_bank #(.WIDTH(WIDTH), .NREGS(NREGS), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset(reset), .penable(penable), .stalled(stalled),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_op(wr_op), .din(din),
        .dec_en(dec_en), .dec_idx(dec_idx),
        .swap_en(swap_en), .swap_a(swap_a), .swap_b(swap_b),
        .rd_idx(rd_idx), .dout(dout), .dout_all(dout_all), .nonzero(nonzero),
        .dec_cond(dec_cond), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mov_src(input logic [1:0] op, input logic [31:0] d);
        logic [31:0] r;
        if (op == 2'b01) r = ~d;
        else if (op == 2'b10) r = {<<{d}};
        else r = d;
        return r;
    endfunction

    function automatic logic [31:0] m_read(input logic [1:0] idx);
        return (idx < 3) ? m_regs[idx] : 32'h0;
    endfunction

    function automatic logic [95:0] m_all();
        return {m_regs[2], m_regs[1], m_regs[0]};
    endfunction

    function automatic logic [2:0] m_nonzero();
        logic [2:0] n;
        for (int i = 0; i < 3; i++) n[i] = (m_regs[i] != 0);
        return n;
    endfunction

    // Reference: build the post-edge state from the rules, later rules override earlier.
    task automatic model_update();
        logic [31:0] n [3];
        logic [2:0]  nu;
        logic        sw;
        if (reset) begin
            for (int i = 0; i < 3; i++) m_regs[i] = 0;
            m_uf = 0;
        end else if (penable && !stalled) begin
            n  = m_regs;
            nu = m_uf;
            sw = swap_en && swap_a < 3 && swap_b < 3 && swap_a != swap_b;
            if (dec_en && dec_idx < 3 && !(sw && (dec_idx == swap_a || dec_idx == swap_b))) begin
                if (m_regs[dec_idx] == 0) nu[dec_idx] = 1'b1;
                n[dec_idx] = m_regs[dec_idx] - 32'd1;
            end
            if (sw) begin
                n[swap_a]  = m_regs[swap_b];
                n[swap_b]  = m_regs[swap_a];
                nu[swap_a] = m_uf[swap_b];
                nu[swap_b] = m_uf[swap_a];
            end
            if (wr_en && wr_idx < 3) begin
                n[wr_idx]  = mov_src(wr_op, din);
                nu[wr_idx] = 1'b0;
            end
            m_regs = n;
            m_uf   = nu;
        end
    endtask

    // One clock: pre-edge combinational checks, edge, post-edge state checks.
    task automatic step(input bit pre_chk);
        #1;
        if (pre_chk) begin
            check("dec_cond", dec_cond, (dec_idx < 3) && (m_read(dec_idx) != 0));
            check("dout", dout, m_read(rd_idx));
        end
        @(posedge clk);
        model_update();
        #1;
        check("dout_all", dout_all, m_all());
        check("nonzero", nonzero, m_nonzero());
        check("underflow", underflow, m_uf);
    endtask

    task automatic idle();
        reset = 0; penable = 1; stalled = 0;
        wr_en = 0; wr_idx = 0; wr_op = 0; din = 0;
        dec_en = 0; dec_idx = 0;
        swap_en = 0; swap_a = 0; swap_b = 0; rd_idx = 0;
    endtask

    task automatic write(input logic [1:0] idx, input logic [1:0] op, input logic [31:0] d);
        idle();
        wr_en = 1; wr_idx = idx; wr_op = op; din = d;
        step(1);
    endtask

    logic seq [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        idle();
        reset = 1; wr_en = 1; din = 32'hAB;
        @(posedge clk);
        step(0);
        idle();
        #1;
        check("rst_all", dout_all, 96'h0);
        check("rst_nonzero", nonzero, 3'b000);
        check("rst_underflow", underflow, 3'b000);
        check("rst_dec_cond", dec_cond, 1'b0);
        check("rst_dout", dout, 32'h0);

        // Countdown through zero
        write(0, 2'b00, 32'h3);
        idle(); dec_en = 1; dec_idx = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("jmp_seq", dec_cond, seq[k]);
            step(1);
        end
        check("x_wrapped", dout_all[31:0], 32'hFFFF_FFFF);
        check("x_uf", underflow[0], 1'b1);
        check("x_nz", nonzero[0], 1'b1);

        // Y underflows, then MOV-style writes clear the flag
        idle(); dec_en = 1; dec_idx = 1; step(1);
        check("y_uf_set", underflow[1], 1'b1);
        write(1, 2'b01, 32'h0000_FFFF);
        check("y_inv", dout_all[63:32], 32'hFFFF_0000);
        check("y_uf_clr", underflow[1], 1'b0);
        write(1, 2'b10, 32'h0000_0001);
        check("y_rev", dout_all[63:32], 32'h8000_0000);

        // Swap with concurrent write to one operand
        write(0, 2'b00, 32'h11);
        write(1, 2'b00, 32'h22);
        idle(); swap_en = 1; swap_a = 0; swap_b = 1; wr_en = 1; wr_idx = 0; din = 32'h55;
        step(1);
        check("swap_wr_x", dout_all[31:0], 32'h55);
        check("swap_wr_y", dout_all[63:32], 32'h11);

        // Stall and clock-enable gating
        write(0, 2'b00, 32'h10);
        idle(); stalled = 1; dec_en = 1; wr_en = 1; din = 32'h99;
        #1; check("stall_cond", dec_cond, 1'b1);
        step(1);
        check("stall_hold", dout_all[31:0], 32'h10);
        stalled = 0; penable = 0;
        step(1);
        check("pen_hold", dout_all[31:0], 32'h10);
        penable = 1;
        step(1);
        check("release", dout_all[31:0], 32'h99);

        // Disjoint write + wrapping decrement
        write(0, 2'b00, 32'h5);
        write(1, 2'b00, 32'h0);
        idle(); dec_en = 1; dec_idx = 1; wr_en = 1; wr_idx = 0; din = 32'h7;
        step(1);
        check("dj_x", dout_all[31:0], 32'h7);
        check("dj_y", dout_all[63:32], 32'hFFFF_FFFF);
        check("dj_uf", underflow, 3'b010);

        // Out-of-range indices do nothing
        idle(); wr_en = 1; wr_idx = 3; din = 32'h1234; dec_en = 1; dec_idx = 3;
        swap_en = 1; swap_a = 0; swap_b = 3; rd_idx = 3;
        #1;
        check("oor_dout", dout, 32'h0);
        check("oor_cond", dec_cond, 1'b0);
        step(1);
        check("oor_x", dout_all[31:0], 32'h7);

        // Reset beats a concurrent write
        write(0, 2'b00, 32'h0);
        idle(); dec_en = 1; step(1);
        check("pre_rst_uf", underflow[0], 1'b1);
        idle(); reset = 1; wr_en = 1; din = 32'hAB;
        step(1);
        check("rst_wr_all", dout_all, 96'h0);
        check("rst_wr_uf", underflow, 3'b000);

        // Randomised traffic
        for (int n = 0; n < 800; n++) begin
            reset   = ($urandom_range(0, 49) == 0);
            penable = ($urandom_range(0, 7) != 0);
            stalled = ($urandom_range(0, 7) == 0);
            wr_en   = ($urandom_range(0, 2) == 0);
            wr_idx  = 2'($urandom_range(0, 3));
            wr_op   = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: din = 32'h0;
                1: din = 32'h1;
                2: din = 32'($urandom_range(0, 3));
                default: din = $urandom;
            endcase
            dec_en  = ($urandom_range(0, 2) != 0);
            dec_idx = 2'($urandom_range(0, 3));
            swap_en = ($urandom_range(0, 2) == 0);
            swap_a  = 2'($urandom_range(0, 3));
            swap_b  = 2'($urandom_range(0, 3));
            rd_idx  = 2'($urandom_range(0, 3));
            step(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pio_scratch_bank.md
Name: pio_scratch_bank

Overview:
Parametrised bank of PIO scratch registers, generalising the single X/Y scratch register to NREGS registers of WIDTH bits. Per cycle it supports:
- one write with a MOV-style source operation (pass, invert, bit-reverse);
- one decrement carrying JMP X-- style pre-decrement condition;
- one register-to-register swap.

It tracks a sticky underflow flag per register. It sits in the PIO state machine datapath, between the instruction decoder and the condition/MOV/OUT logic.

Parameters:
WIDTH, 32, bit width of each register (>=2)
NREGS, 2, number of registers (>=2; index 0 = X, 1 = Y)
IDX_W, 1, index width; must satisfy 2**IDX_W >= NREGS

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous active-high reset
penable  input  1  state-machine clock enable
stalled  input  1  current instruction stalled; blocks all updates
wr_en  input  1  write request
wr_idx  input  IDX_W  write target
wr_op  input  2  00 pass, 01 bitwise invert, 10 bit-reverse, 11 pass
din  input  WIDTH  write source data
dec_en  input  1  decrement request
dec_idx  input  IDX_W  decrement target
swap_en  input  1  swap request
swap_a  input  IDX_W  swap operand A
swap_b  input  IDX_W  swap operand B
rd_idx  input  IDX_W  read select
dout  output  WIDTH  value of register rd_idx (combinational); 0 if rd_idx >= NREGS
dout_all  output  NREGS*WIDTH  all registers; reg i at bits [i*WIDTH +: WIDTH]
nonzero  output  NREGS  bit i = (reg i != 0), combinational from current state
dec_cond  output  1  reg[dec_idx] != 0 before decrement (JMP X-- condition); combinational; 0 if dec_idx out of range
underflow  output  NREGS  sticky: set when a decrement wraps 0 -> all-ones

Behaviour:
- Reset (synchronous, highest priority): all registers = 0; underflow = 0. Consequently dout = 0, nonzero = 0, dec_cond = 0.
- Update enable: state changes only on an edge where penable=1 and stalled=0. Otherwise all state holds, regardless of wr_en/dec_en/swap_en.
- Latency: a write, decrement or swap is visible on dout/dout_all/nonzero the cycle after the enabling edge. dec_cond always reflects pre-update state.
- Write: reg[wr_idx] <= f(din), where f depends on wr_op:
  - invert = ~din;
  - bit-reverse: result bit k = din[WIDTH-1-k];
  - pass otherwise.
  - A write clears underflow[wr_idx].
- Decrement: reg <= reg - 1, modulo 2**WIDTH. If reg == 0 the result wraps to all-ones and underflow[dec_idx] <= 1. dec_cond is computed from the pre-decrement value, so 1 -> 0 gives dec_cond=1 and 0 -> all-ones gives dec_cond=0.
- Swap: reg[a] <= old reg[b] and reg[b] <= old reg[a]; underflow bits are exchanged too. swap_a == swap_b is a no-op.
- Simultaneous operations, per-register priority write > swap > decrement:
  - Write to a swap operand: that register takes the written value. The other operand still receives the old (pre-edge) value of the written register.
  - Decrement of a swap operand: the decrement is dropped (no wrap, no underflow). dec_cond output is unaffected.
  - Write and decrement to the same register: write wins, and underflow is cleared.
  - Operations on disjoint registers all apply in the same cycle.
- Out-of-range index (>= NREGS):
  - write/decrement to it is ignored;
  - a swap with any out-of-range operand is ignored entirely.
- Arithmetic: pure WIDTH-bit unsigned; no saturation.

Test Plan:
- Reset, then write X=0x00000003 (pass). Decrement 4 times with penable=1 -> dec_cond sequence 1,1,1,0; X ends 0xFFFFFFFF; underflow[0]=1, nonzero[0]=1.
- Write Y with wr_op=01, din=0x0000FFFF -> Y=0xFFFF0000. Write Y with wr_op=10, din=0x00000001 -> Y=0x80000000. Both writes clear underflow[1].
- X=0x11, Y=0x22. Assert swap_en (a=0, b=1) with wr_en to idx 0, din=0x55, same edge -> X=0x55, Y=0x11.
- X=0x10, stalled=1 (and separately penable=0), assert dec_en and wr_en(0x99) -> X stays 0x10, dec_cond=1. Release stall -> X=0x99.
- X=5, Y=0. Decrement Y and write X=7 on the same edge -> X=7, Y=0xFFFFFFFF, underflow=2'b10.
- With underflow[0]=1, assert reset for one cycle while wr_en=1, din=0xAB -> all registers 0, underflow 0; the write is discarded.
